// File: rtl/bcd_seg_encoder.sv
// -----------------------------------------------------------------------------
// bcd_seg_encoder
//
// Converts a 10-bit unsigned binary value into three 7-segment digit bytes
// (hundreds, tens, units) for a TM1638 display driver. The conversion uses a
// sequential double-dabble (shift-and-add-3) over 10 cycles. Each digit is
// then decoded to a segment byte, and a one-cycle frame strobe is issued.
//
// Fixed frame timing, counted from the edge that accepts start (edge 0):
//   edges 1..10 : double-dabble iterations (SHIFT)
//   edge  11    : segment bytes loaded (ENCODE -> DONE)
//   edge  12    : return to IDLE; synch2 is high for the following cycle
// If start is held high, a new frame begins every 13 cycles.
//
// Parameters
//   OVF_PATTERN  segment byte shown on all three digits when value > 999
//
// Configuration macro
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits are driven 8'h00
//                          (the units digit is never blanked)
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   conversion request, accepted only in IDLE
//   value   in   [9:0] binary value, captured when start is accepted
//   busy    out  high whenever the FSM is not in IDLE (registered)
//   data1   out  [7:0] hundreds segment byte (bit0=a .. bit6=g, bit7=dp=0)
//   data2   out  [7:0] tens segment byte
//   data3   out  [7:0] units segment byte
//   synch2  out  one-cycle frame-valid strobe (registered)
// -----------------------------------------------------------------------------
module bcd_seg_encoder #(
    parameter logic [7:0] OVF_PATTERN = 8'h40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] value,
    output logic       busy,
    output logic [7:0] data1,
    output logic [7:0] data2,
    output logic [7:0] data3,
    output logic       synch2
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'd9;

    state_t      state;
    state_t      state_nxt;

    logic [9:0]  bin_q;     // binary value being shifted out MSB first
    logic [11:0] bcd_q;     // three BCD nibbles: [11:8] hundreds .. [3:0] units
    logic [3:0]  iter_q;    // double-dabble iteration index, 0..9
    logic        ovf_q;     // captured value was above 999

    logic [11:0] bcd_adj;
    logic [11:0] bcd_nxt;
    logic [7:0]  seg_h;
    logic [7:0]  seg_t;
    logic [7:0]  seg_u;

    // Digit to segment byte, active-high, decimal point always off.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'h3F;
            4'd1:    seg7 = 8'h06;
            4'd2:    seg7 = 8'h5B;
            4'd3:    seg7 = 8'h4F;
            4'd4:    seg7 = 8'h66;
            4'd5:    seg7 = 8'h6D;
            4'd6:    seg7 = 8'h7D;
            4'd7:    seg7 = 8'h07;
            4'd8:    seg7 = 8'h7F;
            4'd9:    seg7 = 8'h6F;
            default: seg7 = 8'h00;
        endcase
    endfunction

    // Add 3 to a nibble that is 5 or more, so that the following left shift
    // carries into the next decimal digit instead of producing 10..15.
    function automatic logic [3:0] dabble_adj(input logic [3:0] n);
        dabble_adj = (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // One double-dabble step: adjust every nibble, then shift in the next
    // binary MSB. For inputs up to 999 the result fits in 12 bits.
    always_comb begin
        bcd_adj = {dabble_adj(bcd_q[11:8]), dabble_adj(bcd_q[7:4]), dabble_adj(bcd_q[3:0])};
        bcd_nxt = {bcd_adj[10:0], bin_q[9]};
    end

    // Segment bytes presented to the output registers at the ENCODE edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path through the branches leaves it unassigned (no latch).
        seg_h = seg7(bcd_q[11:8]);
        seg_t = seg7(bcd_q[7:4]);
        seg_u = seg7(bcd_q[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
        if (bcd_q[11:8] == 4'd0) begin
            seg_h = 8'h00;
            if (bcd_q[7:4] == 4'd0) begin
                seg_t = 8'h00;
            end
        end
`endif
        if (ovf_q) begin
            seg_h = OVF_PATTERN;
            seg_t = OVF_PATTERN;
            seg_u = OVF_PATTERN;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (iter_q == LAST_ITER) state_nxt = ENCODE;
            ENCODE:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            synch2 <= 1'b0;
            data1  <= 8'h00;
            data2  <= 8'h00;
            data3  <= 8'h00;
            bin_q  <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy   <= (state_nxt != IDLE);
            // Strobe follows the DONE cycle, i.e. the cycle after edge 12.
            synch2 <= (state == DONE);

            case (state)
                IDLE: begin
                    if (start) begin
                        bin_q  <= value;
                        bcd_q  <= '0;
                        iter_q <= '0;
                        ovf_q  <= (value > 10'd999);
                    end
                end
                SHIFT: begin
                    bin_q  <= {bin_q[8:0], 1'b0};
                    bcd_q  <= bcd_nxt;
                    iter_q <= iter_q + 4'd1;
                end
                ENCODE: begin
                    data1 <= seg_h;
                    data2 <= seg_t;
                    data3 <= seg_u;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seg_encoder.sv
// -----------------------------------------------------------------------------
// tb_bcd_seg_encoder
//
// Self-checking bench for bcd_seg_encoder. Expected segment bytes come from a
// reference model that splits the value into decimal digits with division and
// modulo and looks them up in a segment table. Frame timing (busy, synch2,
// output update edge) is checked cycle by cycle against the fixed 13-cycle
// frame. Covers reset state, directed corner values, overflow, ignored start
// requests, mid-conversion reset, back-to-back frames and random values.
// -----------------------------------------------------------------------------
module tb_bcd_seg_encoder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] value;
    logic       busy;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [7:0] data3;
    logic       synch2;

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] exp_prev;   // frame currently expected on data1..data3

    bcd_seg_encoder #(.OVF_PATTERN(8'h40)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .value  (value),
        .busy   (busy),
        .data1  (data1),
        .data2  (data2),
        .data3  (data3),
        .synch2 (synch2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: decimal digits by arithmetic, segment table lookup.
    function automatic logic [23:0] model(input int v);
        logic [7:0] seg_tab [10];
        int h, t, u;
        logic [7:0] b1, b2, b3;
        seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        if (v > 999) return {8'h40, 8'h40, 8'h40};
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        b1 = seg_tab[h];
        b2 = seg_tab[t];
        b3 = seg_tab[u];
`ifdef LEADING_ZERO_BLANK_EN
        if (h == 0) b1 = 8'h00;
        if (h == 0 && t == 0) b2 = 8'h00;
`endif
        return {b1, b2, b3};
    endfunction

    // Advance one clock; sampling happens 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full frame from IDLE. With hold=1, start stays high and value is
    // scrambled during the conversion to prove it was captured at acceptance.
    task automatic convert(input logic [9:0] v, input bit hold);
        logic [23:0] exp_new;
        exp_new = model(int'(v));
        value = v;
        start = 1'b1;
        tick();                                   // acceptance edge
        check("busy_accept", {31'd0, busy}, 32'd1);
        check("synch2_accept", {31'd0, synch2}, 32'd0);
        if (hold) value = 10'($urandom_range(0, 1023));
        else      start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 10) check("data_hold", {8'd0, data1, data2, data3}, {8'd0, exp_prev});
            if (k == 11) check("data_new", {8'd0, data1, data2, data3}, {8'd0, exp_new});
            check("synch2_frame", {31'd0, synch2}, (k == 12) ? 32'd1 : 32'd0);
            check("busy_frame", {31'd0, busy}, (k == 12) ? 32'd0 : 32'd1);
        end
        exp_prev = exp_new;
        if (!hold) begin
            tick();
            check("synch2_after", {31'd0, synch2}, 32'd0);
            check("busy_after", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int pulses;
        logic [9:0] v;

        rst   = 1'b1;
        start = 1'b1;      // reset must win over start
        value = 10'd24;
        exp_prev = 24'h000000;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_synch2", {31'd0, synch2}, 32'd0);
        check("rst_data", {8'd0, data1, data2, data3}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;

        // Directed values, first one accepted the cycle rst is sampled low.
        convert(10'd24, 1'b0);
        convert(10'd0, 1'b0);
        convert(10'd905, 1'b0);
        convert(10'd999, 1'b0);
        convert(10'd1000, 1'b0);
        convert(10'd1023, 1'b0);
        convert(10'd24, 1'b0);

        // Start requests during SHIFT (cycle 3) and DONE (cycle 12) are ignored.
        value = 10'd24;
        start = 1'b1;
        tick();
        start = 1'b0;
        value = 10'd7;
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            start = (k == 3 || k == 12);
            tick();
            if (synch2) pulses++;
        end
        start = 1'b0;
        check("ignored_pulses", pulses, 32'd1);
        check("ignored_busy", {31'd0, busy}, 32'd0);
        check("ignored_data", {8'd0, data1, data2, data3}, {8'd0, model(24)});
        exp_prev = model(24);

        // Reset in cycle 5 of a conversion of 555 aborts it.
        value = 10'd555;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_synch2", {31'd0, synch2}, 32'd0);
        check("abort_data", {8'd0, data1, data2, data3}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (synch2) pulses++;
        end
        check("abort_no_pulse", pulses, 32'd0);
        exp_prev = 24'h000000;
        convert(10'd555, 1'b0);

        // start held high: back-to-back frames every 13 cycles.
        for (int f = 0; f < 6; f++) begin
            convert((f % 2) ? 10'd555 : 10'd24, 1'b1);
        end
        start = 1'b0;
        tick();
        check("b2b_end_busy", {31'd0, busy}, 32'd0);

        // Random values across the full input range.
        for (int i = 0; i < 25; i++) begin
            v = 10'($urandom_range(0, 1023));
            convert(v, ($urandom_range(0, 3) == 0));
        end
        start = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_seg_encoder.md
BCD_SEG_ENCODER -- requirements
Module: bcd_seg_encoder

Interface
REQ-001 SHALL have parameter OVF_PATTERN, default 8'h40, the segment byte driven on all three digits when the input exceeds 999.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; every register is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: conversion request, sampled on each clk edge.
REQ-005 SHALL have port value, input, 10 bits: unsigned binary number to display, captured when start is accepted.
REQ-006 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have port data1, output, 8 bits: hundreds-digit segment byte (bit0=a … bit6=g, bit7=dp=0, active-high).
REQ-008 SHALL have port data2, output, 8 bits: tens-digit segment byte, same format.
REQ-009 SHALL have port data3, output, 8 bits: units-digit segment byte, same format.
REQ-010 SHALL have port synch2, output, 1 bit: one-cycle frame-valid strobe to the downstream TM1638 driver.

Function
REQ-011 SHALL implement the FSM states IDLE, SHIFT, ENCODE and DONE.
REQ-012 In IDLE with start=1, SHALL capture value, clear the BCD accumulator and the iteration counter, and enter SHIFT.
REQ-013 In SHIFT, SHALL perform one double-dabble iteration per cycle (add 3 to each BCD nibble >=5, then shift left one bit), for exactly 10 cycles, then enter ENCODE.
REQ-014 In ENCODE, SHALL update data1/data2/data3 from the BCD nibbles using 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, then enter DONE.
REQ-015 In DONE, SHALL drive synch2=1 for exactly one cycle, then return to IDLE.
REQ-016 Latency SHALL be fixed: synch2 is high in the cycle following the 12th rising edge after the edge that accepted start.
REQ-017 data1..data3 SHALL change only at the ENCODE→DONE edge and SHALL hold between frames.
REQ-018 start SHALL be ignored while busy=1, with no queuing.
REQ-019 If start is asserted in the DONE cycle, it SHALL be ignored; a new conversion is accepted only in IDLE.
REQ-020 If the captured value is >999, SHALL drive OVF_PATTERN on all three digits, still with the same latency and synch2 pulse.
REQ-021 The BCD accumulator SHALL be 12 bits and SHALL never wrap for inputs of 0..999.
REQ-022 synch2 and busy SHALL be registered outputs, with no combinational path from start.

Reset
REQ-023 On rst=1 at a clk edge, SHALL enter IDLE and set busy=0, synch2=0, and data1=data2=data3=8'h00.
REQ-024 Reset SHALL take priority over start.
REQ-025 Reset mid-conversion SHALL abort the conversion, produce no synch2 pulse, and blank the outputs.
REQ-026 The first conversion after reset SHALL be accepted the cycle rst is sampled low.

Configuration
REQ-027 With macro LEADING_ZERO_BLANK_EN defined, leading zero digits SHALL be driven 8'h00: data1 blank if hundreds=0; data2 blank if hundreds=0 and tens=0; data3 never blank.
REQ-028 With LEADING_ZERO_BLANK_EN undefined, every digit SHALL show its decoded value, including leading zeros.
REQ-029 The overflow pattern SHALL be unaffected by LEADING_ZERO_BLANK_EN.

Verification
REQ-030 Macro off, value=24, start pulse -> after 12 edges data1=3F, data2=5B, data3=66, synch2 high exactly one cycle.
REQ-031 Macro on, value=24 -> data1=00, data2=5B, data3=66; value=0 -> 00,00,3F; value=905 -> 6F,3F,6D.
REQ-032 value=999 -> 6F,6F,6F; value=1000 and value=1023 -> 40,40,40, each with one synch2 pulse at the same latency.
REQ-033 Convert value=24, then start with value=7 at cycles 3 and 12 after acceptance -> both ignored, only one synch2 pulse, outputs stay 3F,5B,66.
REQ-034 Convert 24, then assert rst at cycle 5 of the next conversion (value=555) -> no synch2, outputs 00,00,00, busy=0; convert 555 next -> 6D,6D,6D.
REQ-035 Hold start=1 continuously, alternating value between 24 and 555 -> one frame every 13 cycles, each frame matching the value captured at acceptance.
